axis_slave: RTL and testbench



---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_slave_fifo.sv | 66 ++++++
 rtl/axis_slave.sv | 78 +++++++
 tb/tb_axis_slave.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream receive endpoint.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_USER_W = 2;

    // One stored beat; last sits in the MSB so a flat vector has the same layout.
    typedef struct packed {
        logic                   last;
        logic [AXIS_USER_W-1:0] user;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    localparam int AXIS_BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/axis_slave_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// rd_data always shows the entry at the read pointer; the wrapper decides
// whether that value is meaningful.
module axis_slave_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    // Writes into a full FIFO and reads from an empty one are ignored.
    assign push_s = wr_en & ~full;
    assign pop_s  = rd_en & ~empty;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array: written on push, never reset (contents are qualified by count).
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and fill-level bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axis_slave.sv
// AXI-Stream slave endpoint: buffers incoming beats in a small FWFT FIFO and
// presents them to a backend over a bk_valid/bk_ready handshake.
module axis_slave
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_W,
    parameter int USER_WIDTH = AXIS_USER_W,
    parameter int DEPTH      = 4
) (
    input  logic                     axi_aclk,
    input  logic                     axi_reset,
    input  logic                     axis_tvalid,
    input  logic [DATA_WIDTH-1:0]    axis_tdata,
    input  logic [3:0]               axis_tstrb,
    input  logic [3:0]               axis_tkeep,
    input  logic                     axis_tlast,
    input  logic [USER_WIDTH-1:0]    axis_tuser,
    output logic                     axis_tready,
    output logic [DATA_WIDTH-1:0]    bk_data,
    output logic [USER_WIDTH-1:0]    bk_user,
    output logic                     bk_last,
    output logic                     bk_valid,
    input  logic                     bk_ready,
    output logic [$clog2(DEPTH):0]   bk_count
);

    localparam int BEAT_W = DATA_WIDTH + USER_WIDTH + 1;

    logic [BEAT_W-1:0] wr_beat_s;
    logic [BEAT_W-1:0] rd_beat_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              unused_s;

    // Strobe and keep are part of the AXIS port set but carry no meaning here.
    assign unused_s = ^{axis_tstrb, axis_tkeep};

    // Ready depends only on stored state and reset, never on bk_ready or tvalid.
    assign axis_tready = ~axi_reset & ~full_s;
    assign bk_valid    = ~empty_s;
    assign push_s      = axis_tvalid & axis_tready;
    assign pop_s       = bk_valid & bk_ready;
    assign wr_beat_s   = {axis_tlast, axis_tuser, axis_tdata};

    axis_slave_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst     (axi_reset),
        .wr_en   (push_s),
        .wr_data (wr_beat_s),
        .rd_en   (pop_s),
        .rd_data (rd_beat_s),
        .count   (bk_count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Present the head beat only while it is valid; stale storage reads as zero.
    always_comb begin
        bk_data = {DATA_WIDTH{1'b0}};
        bk_user = {USER_WIDTH{1'b0}};
        bk_last = 1'b0;
        if (bk_valid) begin
            bk_data = rd_beat_s[DATA_WIDTH-1:0];
            bk_user = rd_beat_s[DATA_WIDTH +: USER_WIDTH];
            bk_last = rd_beat_s[BEAT_W-1];
        end else begin
            bk_data = {DATA_WIDTH{1'b0}};
            bk_user = {USER_WIDTH{1'b0}};
            bk_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_slave.sv
// Self-checking bench for axis_slave: queue-based reference FIFO plus a
// negedge monitor comparing every DUT output against it.
module tb_axis_slave;
    import axis_pkg::*;

    localparam int DEPTH = 4;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic        axis_tlast;
    logic [1:0]  axis_tuser;
    logic        axis_tready;
    logic [31:0] bk_data;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        bk_valid;
    logic        bk_ready;
    logic [2:0]  bk_count;

    int n_vec  = 0;
    int n_err  = 0;
    int n_push = 0;
    int n_recv = 0;

    axis_beat_t ref_q[$];

    axis_slave #(.DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(DEPTH)) dut (
        .axi_aclk    (axi_aclk),
        .axi_reset   (axi_reset),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tready (axis_tready),
        .bk_data     (bk_data),
        .bk_user     (bk_user),
        .bk_last     (bk_last),
        .bk_valid    (bk_valid),
        .bk_ready    (bk_ready),
        .bk_count    (bk_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated by the handshake rules at each edge.
    always @(posedge axi_aclk) begin
        int sz;
        sz = ref_q.size();
        if (axi_reset) begin
            ref_q.delete();
        end else begin
            if (bk_ready && sz > 0) void'(ref_q.pop_front());
            if (axis_tvalid && sz < DEPTH) begin
                ref_q.push_back({axis_tlast, axis_tuser, axis_tdata});
                n_push++;
            end
        end
    end

    // Monitor: compare DUT outputs to the model away from the active edge.
    always @(negedge axi_aclk) begin
        int sz;
        sz = ref_q.size();
        chk("tready", axis_tready, (!axi_reset && sz != DEPTH));
        chk("valid", bk_valid, (sz != 0));
        chk("count", bk_count, sz);
        if (sz != 0) begin
            chk("data", bk_data, ref_q[0].data);
            chk("user", bk_user, ref_q[0].user);
            chk("last", bk_last, ref_q[0].last);
            if (bk_ready && !axi_reset) n_recv++;
        end else begin
            chk("data_zero", {bk_last, bk_user, bk_data}, 35'd0);
        end
    end

    task automatic cyc();
        @(posedge axi_aclk);
        #1;
    endtask

    // Hold one beat until accepted (bounded); returns at #1 after the accept edge.
    task automatic send(input logic [31:0] d, input logic [1:0] u, input logic l);
        logic acc;
        acc = 1'b0;
        axis_tvalid = 1'b1;
        axis_tdata  = d;
        axis_tuser  = u;
        axis_tlast  = l;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge axi_aclk);
            acc = axis_tready;
            cyc();
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got not-accepted expected accepted");
        end
        axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        bk_ready = 1'b1;
        for (int k = 0; k < 50 && bk_count != 3'd0; k++) cyc();
        cyc();
        chk("drain_empty", bk_count, 3'd0);
        bk_ready = 1'b0;
    endtask

    initial begin
        int base;
        logic acc;
        axi_reset   = 1'b1;
        axis_tvalid = 1'b1;
        axis_tdata  = 32'h0;
        axis_tuser  = 2'b00;
        axis_tlast  = 1'b0;
        axis_tstrb  = 4'hF;
        axis_tkeep  = 4'hF;
        bk_ready    = 1'b0;

        // Reset held 3 cycles with tvalid asserted
        repeat (3) cyc();
        chk("rst_tready", axis_tready, 1'b0);
        chk("rst_count", bk_count, 3'd0);
        axi_reset   = 1'b0;
        axis_tvalid = 1'b0;
        @(negedge axi_aclk);
        chk("post_rst_tready", axis_tready, 1'b1);
        cyc();

        // Single beat
        send(32'hDEADBEEF, 2'b10, 1'b1);
        chk("sb_valid", bk_valid, 1'b1);
        chk("sb_data", bk_data, 32'hDEADBEEF);
        chk("sb_user", bk_user, 2'd2);
        chk("sb_last", bk_last, 1'b1);
        chk("sb_count", bk_count, 3'd1);
        bk_ready = 1'b1;
        cyc();
        bk_ready = 1'b0;
        chk("sb_pop_valid", bk_valid, 1'b0);
        chk("sb_pop_count", bk_count, 3'd0);

        // Fill to full, fifth beat held off
        for (int i = 1; i <= 4; i++) send(32'(i), 2'(i), 1'b0);
        chk("full_count", bk_count, 3'd4);
        chk("full_tready", axis_tready, 1'b0);
        axis_tvalid = 1'b1;
        axis_tdata  = 32'h5;
        repeat (3) cyc();
        chk("full_hold", bk_count, 3'd4);
        bk_ready = 1'b1;
        cyc();
        bk_ready = 1'b0;
        chk("full_pop_head", bk_data, 32'h2);
        chk("full_pop_tready", axis_tready, 1'b1);
        cyc();
        axis_tvalid = 1'b0;
        chk("full_refill", bk_count, 3'd4);
        drain();

        // Streaming at one beat per cycle
        base = n_recv;
        bk_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            axis_tvalid = 1'b1;
            axis_tdata  = 32'(i);
            axis_tuser  = 2'(i);
            axis_tlast  = (i == 15);
            @(negedge axi_aclk);
            chk("stream_cnt_le1", (bk_count <= 3'd1), 1'b1);
            chk("stream_tready", axis_tready, 1'b1);
            cyc();
        end
        axis_tvalid = 1'b0;
        drain();
        chk("stream_delivered", n_recv - base, 16);

        // Random traffic with backpressure on both sides
        for (int b = 0; b < 100; ) begin
            if (!axis_tvalid) begin
                axis_tvalid = ($urandom_range(0, 3) != 0);
                axis_tdata  = $urandom;
                axis_tuser  = 2'($urandom_range(0, 3));
                axis_tlast  = 1'($urandom_range(0, 1));
            end
            bk_ready = ($urandom_range(0, 2) != 0);
            @(negedge axi_aclk);
            acc = axis_tvalid && axis_tready;
            chk("rand_count_range", (bk_count <= 3'd4), 1'b1);
            cyc();
            if (acc) begin
                b++;
                axis_tvalid = 1'b0;
            end
        end
        axis_tvalid = 1'b0;
        drain();
        chk("no_loss", n_recv, n_push);

        // Reset with beats stored
        for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), 2'b01, 1'b0);
        chk("mid_pre_count", bk_count, 3'd3);
        axi_reset = 1'b1;
        cyc();
        axi_reset = 1'b0;
        chk("mid_count", bk_count, 3'd0);
        chk("mid_valid", bk_valid, 1'b0);
        send(32'hA5, 2'b11, 1'b1);
        chk("mid_new_head", bk_data, 32'hA5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
